// File: rtl/vend_sequencer.sv
// Coin arbitration, credit accumulation, dispense handshake and change return for the 15-unit vending core.
// Optional feature: define CANCEL_REFUND_EN to let 'cancel' refund the collected credit as change pulses.
module vend_sequencer #(
  parameter int PRICE_UNITS = 3,
  parameter int CREDIT_W    = 3,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_a_valid,
  input  logic [1:0]          coin_a_val,
  output logic                coin_a_ready,
  input  logic                coin_b_valid,
  input  logic [1:0]          coin_b_val,
  output logic                coin_b_ready,
  input  logic                cancel,
  output logic                disp_req,
  input  logic                disp_done,
  output logic                change_pulse,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                fault
);

  localparam logic [1:0] COLLECT  = 2'd0;
  localparam logic [1:0] DISPENSE = 2'd1;
  localparam logic [1:0] CHANGE   = 2'd2;
  localparam logic [1:0] LOCKED   = 2'd3;

  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE_UNITS);
  localparam logic [TO_W-1:0]     TIMEOUT_C = TO_W'(TIMEOUT);

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] changeCnt_q, changeCnt_d;
  logic [TO_W-1:0]     toCnt_q, toCnt_d;
  logic                pulse_q, pulse_d;
  logic                fault_q, fault_d;
  logic                lastB_q, lastB_d;
  logic                dispReq_q, busy_q;

  logic                grantA, grantB, cancelHit, acceptOk;
  logic [1:0]          selVal;
  logic [CREDIT_W-1:0] coinUnits, creditSum;

`ifdef CANCEL_REFUND_EN
  assign cancelHit = cancel && (credit_q != '0);
`else
  logic unusedCancel;
  assign unusedCancel = cancel;
  assign cancelHit    = 1'b0;
`endif

  // Round-robin: when both channels offer a coin, the one not granted last time wins.
  assign grantA   = coin_a_valid && (!coin_b_valid || lastB_q);
  assign grantB   = coin_b_valid && !grantA;
  assign acceptOk = (state_q == COLLECT) && !cancelHit;

  assign coin_a_ready = acceptOk && grantA;
  assign coin_b_ready = acceptOk && grantB;

  assign selVal = grantA ? coin_a_val : coin_b_val;

  always_comb begin
    case (selVal)
      2'b01:   coinUnits = CREDIT_W'(1);
      2'b10:   coinUnits = CREDIT_W'(2);
      2'b11:   coinUnits = CREDIT_W'(4);
      default: coinUnits = '0;
    endcase
  end

  assign creditSum = credit_q + coinUnits;

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    changeCnt_d = changeCnt_q;
    toCnt_d     = '0;
    pulse_d     = 1'b0;
    fault_d     = fault_q;
    lastB_d     = lastB_q;
    case (state_q)
      COLLECT: begin
        if (cancelHit) begin
          changeCnt_d = credit_q;
          credit_d    = '0;
          pulse_d     = 1'b1;
          state_d     = CHANGE;
        end else if (grantA || grantB) begin
          lastB_d = grantB;
          if (creditSum >= PRICE_C) begin
            changeCnt_d = creditSum - PRICE_C;
            credit_d    = '0;
            state_d     = DISPENSE;
          end else begin
            credit_d = creditSum;
          end
        end
      end
      DISPENSE: begin
        toCnt_d = toCnt_q + 1'b1;
        // A completion arriving on the timeout cycle still counts as a normal vend.
        if (disp_done) begin
          if (changeCnt_q != '0) begin
            pulse_d = 1'b1;
            state_d = CHANGE;
          end else begin
            state_d = COLLECT;
          end
        end else if (toCnt_q == TIMEOUT_C) begin
          fault_d     = 1'b1;
          changeCnt_d = changeCnt_q + PRICE_C;
          pulse_d     = 1'b1;
          state_d     = CHANGE;
        end
      end
      CHANGE: begin
        if (pulse_q) begin
          changeCnt_d = changeCnt_q - 1'b1;
        end else if (changeCnt_q == '0) begin
          state_d = fault_q ? LOCKED : COLLECT;
        end else begin
          pulse_d = 1'b1;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= COLLECT;
      credit_q    <= '0;
      changeCnt_q <= '0;
      toCnt_q     <= '0;
      pulse_q     <= 1'b0;
      fault_q     <= 1'b0;
      lastB_q     <= 1'b1;
      dispReq_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      changeCnt_q <= changeCnt_d;
      toCnt_q     <= toCnt_d;
      pulse_q     <= pulse_d;
      fault_q     <= fault_d;
      lastB_q     <= lastB_d;
      dispReq_q   <= (state_d == DISPENSE);
      busy_q      <= (state_d != COLLECT);
    end
  end

  assign disp_req     = dispReq_q;
  assign change_pulse = pulse_q;
  assign credit       = credit_q;
  assign busy         = busy_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Randomized bench for vend_sequencer against a timeline-based reference model.
// Cancel expectations follow the CANCEL_REFUND_EN macro, matching the DUT build.
module tb_vend_sequencer;

  localparam int PRICE = 3;
  localparam int CW    = 3;
  localparam int TMO   = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          coin_a_valid, coin_b_valid, cancel, disp_done;
  logic [1:0]    coin_a_val, coin_b_val;
  logic          coin_a_ready, coin_b_ready, disp_req, change_pulse, busy, fault;
  logic [CW-1:0] credit;

  int checks = 0;
  int errors = 0;

  // Reference model: outputs are derived from event timestamps rather than a state register.
  int cyc        = 0;
  int mCredit    = 0;
  bit mLastB     = 1'b1;
  bit mFault     = 1'b0;
  bit mDisp      = 1'b0;
  int mDispStart = 0;
  int mPend      = 0;
  int mChgStart  = 0;
  int mChgLen    = 0;

  vend_sequencer #(.PRICE_UNITS(PRICE), .CREDIT_W(CW), .TIMEOUT(TMO), .TO_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .coin_a_valid (coin_a_valid),
    .coin_a_val   (coin_a_val),
    .coin_a_ready (coin_a_ready),
    .coin_b_valid (coin_b_valid),
    .coin_b_val   (coin_b_val),
    .coin_b_ready (coin_b_ready),
    .cancel       (cancel),
    .disp_req     (disp_req),
    .disp_done    (disp_done),
    .change_pulse (change_pulse),
    .credit       (credit),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit mInChange();
    return (mChgLen > 0) && (cyc >= mChgStart) && (cyc < mChgStart + 2 * mChgLen);
  endfunction

  function automatic bit mPulse();
    return mInChange() && (((cyc - mChgStart) % 2) == 0);
  endfunction

  function automatic bit mCollect();
    return !mDisp && !mInChange() && !mFault;
  endfunction

  function automatic int units(input logic [1:0] v);
    case (v)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic applyStimulus(input bit rstN, input bit aV, input logic [1:0] aVal,
                               input bit bV, input logic [1:0] bVal, input bit can, input bit done);
    bit grantA, grantB, cancelHit, okay;
    int sum;
    @(negedge clock);
    reset        = rstN;
    coin_a_valid = aV;
    coin_a_val   = aVal;
    coin_b_valid = bV;
    coin_b_val   = bVal;
    cancel       = can;
    disp_done    = done;
    #1;
    grantA    = aV && (!bV || mLastB);
    grantB    = bV && !grantA;
    cancelHit = 1'b0;
`ifdef CANCEL_REFUND_EN
    cancelHit = can && (mCredit > 0);
`endif
    okay = mCollect() && !cancelHit;
    checkOutput("coin_a_ready", coin_a_ready, okay && grantA);
    checkOutput("coin_b_ready", coin_b_ready, okay && grantB);
    @(posedge clock);
    if (!rstN) begin
      mCredit = 0; mLastB = 1'b1; mFault = 1'b0; mDisp = 1'b0; mPend = 0; mChgLen = 0;
    end else if (mCollect()) begin
      if (cancelHit) begin
        mChgStart = cyc + 1;
        mChgLen   = mCredit;
        mCredit   = 0;
      end else if (grantA || grantB) begin
        mLastB = grantB;
        sum    = mCredit + units(grantA ? aVal : bVal);
        if (sum >= PRICE) begin
          mDisp      = 1'b1;
          mDispStart = cyc + 1;
          mPend      = sum - PRICE;
          mCredit    = 0;
        end else begin
          mCredit = sum;
        end
      end
    end else if (mDisp) begin
      if (done) begin
        mDisp = 1'b0;
        if (mPend > 0) begin
          mChgStart = cyc + 1;
          mChgLen   = mPend;
        end
      end else if (cyc - mDispStart == TMO) begin
        mDisp     = 1'b0;
        mFault    = 1'b1;
        mChgStart = cyc + 1;
        mChgLen   = mPend + PRICE;
      end
    end
    cyc++;
    #1;
    checkOutput("credit", credit, mCredit);
    checkOutput("disp_req", disp_req, mDisp);
    checkOutput("change_pulse", change_pulse, mPulse());
    checkOutput("busy", busy, !mCollect());
    checkOutput("fault", fault, mFault);
  endtask

  task automatic idle(input int n, input bit done);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, done);
  endtask

  initial begin
    bit rstN;
    reset = 1'b0; coin_a_valid = 1'b0; coin_b_valid = 1'b0;
    coin_a_val = 2'b00; coin_b_val = 2'b00; cancel = 1'b0; disp_done = 1'b0;
    repeat (2) @(posedge clock);

    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b1, 2'b11, 1'b1, 1'b1);

    // 10 then 5: exact price, no change
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(3, 1'b0); idle(1, 1'b1); idle(3, 1'b0);

    // 20: one change pulse
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(2, 1'b0); idle(1, 1'b1); idle(4, 1'b0);

    // both channels with 5s: A, B, A then B held off
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0);
    idle(1, 1'b1); idle(2, 1'b0);

    // invalid code accepted but adds nothing, then 10 + 20 gives three pulses
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0);
    idle(1, 1'b0); idle(1, 1'b1); idle(8, 1'b0);

    // cancel with credit 2 alongside a coin on A
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 1'b0);
    idle(6, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    // timeout: full refund then lock, coins refused until reset
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(TMO + 1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      rstN = ($urandom_range(0, 299) != 0);
      if (mFault && !mDisp && !mInChange() && ($urandom_range(0, 5) == 0)) rstN = 1'b0;
      applyStimulus(rstN, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
